// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with block-wide memory port.
// Optional hit/miss/writeback counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
  parameter int unsigned blocksize = 4,
  parameter int unsigned lines     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               A,
  input  logic [31:0]               WD,
  input  logic                      RE,
  input  logic                      WE,
  output logic [31:0]               RD,
  output logic                      Stall,
  output logic                      MemRE,
  output logic                      MemWE,
  output logic [31:0]               MemA,
  output logic [blocksize*32-1:0]   MemWD,
  input  logic [blocksize*32-1:0]   MemRD,
  input  logic                      MemValid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]               HitCount,
  output logic [31:0]               MissCount,
  output logic [31:0]               WritebackCount
`endif
);

  localparam int unsigned LINE_W = blocksize * 32;
  localparam int unsigned IDX_W  = $clog2(lines);
  localparam int unsigned TAG_W  = 28 - IDX_W;

  typedef enum logic [1:0] {
    S_READY     = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [lines-1:0]  valid_q;
  logic [lines-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [lines];
  logic [LINE_W-1:0] data_q [lines];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_a;
  logic [1:0]        word;
  logic [1:0]        unused_a;
  logic [LINE_W-1:0] line;
  logic              access;
  logic              hit;
  logic              fill_done;
  logic              write_hit;

  assign idx      = A[IDX_W+3:4];
  assign tag_a    = A[31:IDX_W+4];
  assign word     = A[3:2];
  assign unused_a = A[1:0];
  assign line     = data_q[idx];
  assign access   = RE | WE;
  assign hit      = valid_q[idx] & (tag_q[idx] == tag_a);

  assign fill_done = (state_q == S_FILL) & MemValid;
  assign write_hit = (state_q == S_READY) & WE & hit;

  // Read data is served straight from the indexed line for zero-latency hits.
  assign RD = line[{word, 5'b0} +: 32];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_READY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READY: begin
        if (access && !hit)
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_FILL;
      end
      S_WRITEBACK: if (MemValid) state_d = S_FILL;
      S_FILL:      if (MemValid) state_d = S_READY;
      default:     state_d = S_READY;
    endcase
  end

  // Memory request, address and stall decode; MemWD tracks the victim line, stable while stalled.
  always_comb begin
    Stall = 1'b1;
    MemRE = 1'b0;
    MemWE = 1'b0;
    MemA  = '0;
    MemWD = line;
    case (state_q)
      S_READY:     Stall = access & ~hit;
      S_WRITEBACK: begin
        MemWE = 1'b1;
        MemA  = {tag_q[idx], idx, 4'b0};
      end
      S_FILL: begin
        MemRE = 1'b1;
        MemA  = {A[31:4], 4'b0};
      end
      default:     Stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset; an aborted fill leaves them untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        data_q[idx] <= MemRD;
        tag_q[idx]  <= tag_a;
      end else if (write_hit) begin
        data_q[idx][{word, 5'b0} +: 32] <= WD;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (state_q == S_READY) begin
      if (access && hit)            hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_d != S_READY)       miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_d == S_WRITEBACK)   wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign HitCount       = hit_cnt_q;
  assign MissCount      = miss_cnt_q;
  assign WritebackCount = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;

  localparam int MEM_LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  A, WD, RD, MemA;
  logic         RE, WE, Stall, MemRE, MemWE, MemValid;
  logic [127:0] MemWD, MemRD;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HitCount, MissCount, WritebackCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .WD       (WD),
    .RE       (RE),
    .WE       (WE),
    .RD       (RD),
    .Stall    (Stall),
    .MemRE    (MemRE),
    .MemWE    (MemWE),
    .MemA     (MemA),
    .MemWD    (MemWD),
    .MemRD    (MemRD),
    .MemValid (MemValid)
`ifdef DCACHE_STATS_EN
    ,
    .HitCount       (HitCount),
    .MissCount      (MissCount),
    .WritebackCount (WritebackCount)
`endif
  );

  // Block memory: completes a request after MEM_LAT cycles with a one-cycle MemValid pulse.
  logic [127:0] mem [logic [31:0]];
  int mem_cnt = 0;

  initial begin
    MemValid = 1'b0;
    MemRD    = '0;
    forever begin
      @(negedge clk);
      MemValid = 1'b0;
      if (MemRE || MemWE) begin
        mem_cnt++;
        if (mem_cnt == MEM_LAT) begin
          mem_cnt  = 0;
          MemValid = 1'b1;
          if (MemWE) mem[MemA] = MemWD;
          else       MemRD = mem.exists(MemA) ? mem[MemA] : '0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Observations captured by do_access
  logic         stall0, first_re, first_we, both_high, no_traffic;
  logic [31:0]  first_a, fill_a, rd_out;
  logic [127:0] first_wd;
  int           cyc;

  task automatic do_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    @(negedge clk);
    A = addr; WE = wr; RE = ~wr; WD = wdata;
    #1;
    stall0 = Stall; cyc = 0; both_high = 1'b0;
    first_re = 1'b0; first_we = 1'b0; first_a = '0; first_wd = '0; fill_a = '0;
    while (Stall && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (MemRE && MemWE) both_high = 1'b1;
      if (cyc == 1) begin
        first_re = MemRE; first_we = MemWE; first_a = MemA; first_wd = MemWD;
      end
      if (MemRE && fill_a == 32'h0) fill_a = MemA;
    end
    rd_out     = RD;
    no_traffic = !MemRE && !MemWE;
    @(negedge clk);
    RE = 1'b0; WE = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; RE = 1'b0; WE = 1'b0; A = '0; WD = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", Stall); end
    checks++; if (MemRE !== 1'b0) begin errors++; $display("FAIL reset_memre got %0b want 0", MemRE); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL reset_memwe got %0b want 0", MemWE); end
`ifdef DCACHE_STATS_EN
    checks++; if (HitCount !== 32'd0) begin errors++; $display("FAIL reset_hitcnt got %0d want 0", HitCount); end
    checks++; if (MissCount !== 32'd0) begin errors++; $display("FAIL reset_misscnt got %0d want 0", MissCount); end
    checks++; if (WritebackCount !== 32'd0) begin errors++; $display("FAIL reset_wbcnt got %0d want 0", WritebackCount); end
`endif
  endtask

  task automatic test_read_miss;
    do_access(32'h100, 1'b0, 32'h0);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL miss_stall got %0b want 1", stall0); end
    checks++; if (first_re !== 1'b1) begin errors++; $display("FAIL miss_memre got %0b want 1", first_re); end
    checks++; if (first_we !== 1'b0) begin errors++; $display("FAIL miss_memwe got %0b want 0", first_we); end
    checks++; if (first_a !== 32'h100) begin errors++; $display("FAIL miss_mema got %h want 00000100", first_a); end
    checks++; if (cyc != MEM_LAT + 1) begin errors++; $display("FAIL miss_latency got %0d want %0d", cyc, MEM_LAT + 1); end
    checks++; if (rd_out !== 32'h11110000) begin errors++; $display("FAIL miss_rd got %h want 11110000", rd_out); end
    checks++; if (no_traffic !== 1'b1) begin errors++; $display("FAIL miss_req_drop got %0b want 1", no_traffic); end
  endtask

  task automatic test_read_hit;
    do_access(32'h104, 1'b0, 32'h0);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL hit_stall got %0b want 0", stall0); end
    checks++; if (rd_out !== 32'hAAAA5555) begin errors++; $display("FAIL hit_rd got %h want aaaa5555", rd_out); end
    checks++; if (no_traffic !== 1'b1) begin errors++; $display("FAIL hit_traffic got %0b want 1", no_traffic); end
  endtask

  task automatic test_write_hit;
    do_access(32'h108, 1'b1, 32'hDEADBEEF);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL wr_stall got %0b want 0", stall0); end
    do_access(32'h108, 1'b0, 32'h0);
    checks++; if (cyc != 0) begin errors++; $display("FAIL wr_readback_cycles got %0d want 0", cyc); end
    checks++; if (rd_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback got %h want deadbeef", rd_out); end
    checks++; if (no_traffic !== 1'b1) begin errors++; $display("FAIL wr_traffic got %0b want 1", no_traffic); end
    do_access(32'h10C, 1'b0, 32'h0);
    checks++; if (rd_out !== 32'h33333333) begin errors++; $display("FAIL wr_neighbour got %h want 33333333", rd_out); end
  endtask

  task automatic test_dirty_evict;
    logic [127:0] blk;
    do_access(32'h500, 1'b0, 32'h0);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL wb_stall got %0b want 1", stall0); end
    checks++; if (first_we !== 1'b1) begin errors++; $display("FAIL wb_memwe got %0b want 1", first_we); end
    checks++; if (first_re !== 1'b0) begin errors++; $display("FAIL wb_memre got %0b want 0", first_re); end
    checks++; if (first_a !== 32'h100) begin errors++; $display("FAIL wb_mema got %h want 00000100", first_a); end
    checks++; if (first_wd[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_word2 got %h want deadbeef", first_wd[95:64]); end
    checks++; if (first_wd[31:0] !== 32'h11110000) begin errors++; $display("FAIL wb_word0 got %h want 11110000", first_wd[31:0]); end
    checks++; if (fill_a !== 32'h500) begin errors++; $display("FAIL wb_fill_mema got %h want 00000500", fill_a); end
    checks++; if (both_high !== 1'b0) begin errors++; $display("FAIL wb_both_req got %0b want 0", both_high); end
    checks++; if (cyc != 2 * MEM_LAT + 1) begin errors++; $display("FAIL wb_latency got %0d want %0d", cyc, 2 * MEM_LAT + 1); end
    checks++; if (rd_out !== 32'h55550000) begin errors++; $display("FAIL wb_rd got %h want 55550000", rd_out); end
    blk = mem[32'h100];
    checks++; if (blk[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_mem_word got %h want deadbeef", blk[95:64]); end
  endtask

  task automatic test_refetch;
    do_access(32'h108, 1'b0, 32'h0);
    checks++; if (first_re !== 1'b1 || first_we !== 1'b0) begin errors++; $display("FAIL refetch_clean got re=%0b we=%0b want re=1 we=0", first_re, first_we); end
    checks++; if (cyc != MEM_LAT + 1) begin errors++; $display("FAIL refetch_latency got %0d want %0d", cyc, MEM_LAT + 1); end
    checks++; if (rd_out !== 32'hDEADBEEF) begin errors++; $display("FAIL refetch_rd got %h want deadbeef", rd_out); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats(input int hits, input int misses, input int wbs);
    checks++; if (HitCount !== 32'(hits)) begin errors++; $display("FAIL stats_hit got %0d want %0d", HitCount, hits); end
    checks++; if (MissCount !== 32'(misses)) begin errors++; $display("FAIL stats_miss got %0d want %0d", MissCount, misses); end
    checks++; if (WritebackCount !== 32'(wbs)) begin errors++; $display("FAIL stats_wb got %0d want %0d", WritebackCount, wbs); end
  endtask
`endif

  task automatic test_reset_mid_fill;
    @(negedge clk);
    A = 32'h700; RE = 1'b1; WE = 1'b0;
    @(negedge clk); #1;
    checks++; if (MemRE !== 1'b1) begin errors++; $display("FAIL rst_fill_memre got %0b want 1", MemRE); end
    @(negedge clk); #1;
    reset = 1'b1; RE = 1'b0;
    @(negedge clk); #1;
    checks++; if (MemRE !== 1'b0) begin errors++; $display("FAIL rst_memre got %0b want 0", MemRE); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL rst_memwe got %0b want 0", MemWE); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", Stall); end
    reset = 1'b0;
    do_access(32'h700, 1'b0, 32'h0);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL rst_remiss got %0b want 1", stall0); end
    checks++; if (cyc != MEM_LAT + 1) begin errors++; $display("FAIL rst_remiss_latency got %0d want %0d", cyc, MEM_LAT + 1); end
    checks++; if (rd_out !== 32'h77770000) begin errors++; $display("FAIL rst_remiss_rd got %h want 77770000", rd_out); end
  endtask

  initial begin
    mem[32'h100] = {32'h33333333, 32'h22222222, 32'hAAAA5555, 32'h11110000};
    mem[32'h500] = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
    mem[32'h700] = {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000};
    test_reset;
    test_read_miss;
    test_read_hit;
    test_write_hit;
    test_dirty_evict;
    test_refetch;
`ifdef DCACHE_STATS_EN
    test_stats(7, 3, 1);
`endif
    test_reset_mid_fill;
`ifdef DCACHE_STATS_EN
    test_stats(1, 1, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
